// File: rtl/ped_sched_pkg.sv
// Shared definitions for the pedestrian crossing scheduler and traffic FSM benches:
// traffic light encodings and the scheduler state enum.
package ped_sched_pkg;

  localparam logic [1:0] LIGHT_GREEN   = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
  localparam logic [1:0] LIGHT_RED     = 2'b10;
  localparam logic [1:0] LIGHT_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WALK,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/ped_crossing_scheduler_if.sv
// Bundle between the button/light side and the scheduler.
// master: drives requests and light state; slave: the scheduler.
interface ped_crossing_scheduler_if #(
  parameter int N_XWALK = 4
);
  logic [N_XWALK-1:0] ped_req;
  logic [1:0]         traffic_light;
  logic               hold_red;
  logic [N_XWALK-1:0] walk_grant;
  logic               walk_flash;
  logic [N_XWALK-1:0] pending;
  logic               hold_fault;

  modport master (
    output ped_req, traffic_light,
    input  hold_red, walk_grant, walk_flash, pending, hold_fault
  );

  modport slave (
    input  ped_req, traffic_light,
    output hold_red, walk_grant, walk_flash, pending, hold_fault
  );
endinterface

// File: rtl/ped_rr_arbiter.sv
// Combinational round-robin pick: first set pending bit at or after rr_ptr,
// wrapping modulo N_XWALK. Outputs are zero when nothing is pending.
module ped_rr_arbiter #(
  parameter  int N_XWALK = 4,
  localparam int IW      = $clog2(N_XWALK)
) (
  input  logic [N_XWALK-1:0] pending,
  input  logic [IW-1:0]      rr_ptr,
  output logic [N_XWALK-1:0] grant,
  output logic [IW-1:0]      index
);

  int j;

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    grant = '0;
    index = '0;
    j     = 0;
    for (int k = N_XWALK - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_XWALK;
      if (pending[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ped_crossing_scheduler.sv
// Pedestrian crossing scheduler: latches button requests, holds the traffic
// light at red, grants WALK to one crosswalk per hold in round-robin order,
// then all-red clearance and a minimum vehicle gap before the next hold.
// Optional feature macro: PED_FLASH_EN (flashing don't-walk in late WALK).
module ped_crossing_scheduler
  import ped_sched_pkg::*;
#(
  parameter int N_XWALK      = 4,
  parameter int MIN_GAP      = 8,
  parameter int WALK_CYCLES  = 6,
  parameter int CLEAR_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 16
) (
  input logic                      clk_main,
  input logic                      rst_main,
  ped_crossing_scheduler_if.slave  bus
);

  localparam int IW   = $clog2(N_XWALK);
  localparam int CM0  = (HOLD_TIMEOUT > WALK_CYCLES) ? HOLD_TIMEOUT : WALK_CYCLES;
  localparam int CMAX = (CM0 > CLEAR_CYCLES) ? CM0 : CLEAR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GW   = $clog2(MIN_GAP + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [GW-1:0]      gap_cnt;
  logic [IW-1:0]      rr_ptr;
  logic [N_XWALK-1:0] pend, pend_nxt, grant_q;
  logic [N_XWALK-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               hold_q, fault_q, fault_set, enter_walk;

  ped_rr_arbiter #(.N_XWALK(N_XWALK)) u_arb (
    .pending (pend),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  // Next state and phase counter; cnt restarts on every state change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fault_set = 1'b0;
    case (state)
      ST_IDLE:
        if (|pend && gap_cnt == GW'(MIN_GAP)) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      ST_HOLD:
        if (bus.traffic_light == LIGHT_RED) begin
          state_nxt = ST_WALK;
          cnt_nxt   = '0;
        end else begin
          if (cnt != CW'(HOLD_TIMEOUT)) cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(HOLD_TIMEOUT - 1)) fault_set = 1'b1;
        end
      ST_WALK:
        if (cnt == CW'(WALK_CYCLES - 1)) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      ST_CLEAR:
        if (cnt == CW'(CLEAR_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign enter_walk = (state == ST_HOLD) && (state_nxt == ST_WALK);

  // Request latch: the winner is cleared on entry (absorbing a same-cycle
  // press), and further presses on the walking crosswalk are dropped.
  always_comb begin
    pend_nxt = (pend | bus.ped_req) & ~(enter_walk ? arb_grant : grant_q);
  end

  // State, counters, pointer and registered outputs.
  always_ff @(posedge clk_main) begin
    if (rst_main) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      rr_ptr  <= '0;
      pend    <= '0;
      grant_q <= '0;
      hold_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      hold_q  <= (state_nxt != ST_IDLE);
      fault_q <= fault_q | fault_set;
      if (state == ST_IDLE) begin
        if (gap_cnt != GW'(MIN_GAP)) gap_cnt <= gap_cnt + 1'b1;
      end else if (state_nxt == ST_IDLE) begin
        gap_cnt <= '0;
      end
      if (enter_walk) begin
        grant_q <= arb_grant;
        rr_ptr  <= (arb_idx == IW'(N_XWALK - 1)) ? '0 : arb_idx + 1'b1;
      end else if (state_nxt != ST_WALK) begin
        grant_q <= '0;
      end
    end
  end

  assign bus.hold_red   = hold_q;
  assign bus.walk_grant = grant_q;
  assign bus.pending    = pend;
  assign bus.hold_fault = fault_q;

`ifdef PED_FLASH_EN
  logic flash_q;

  // Flash through the second half of WALK, starting high on its first cycle.
  always_ff @(posedge clk_main) begin
    if (rst_main || state_nxt != ST_WALK) flash_q <= 1'b0;
    else if (cnt_nxt == CW'(WALK_CYCLES / 2)) flash_q <= 1'b1;
    else if (cnt_nxt > CW'(WALK_CYCLES / 2)) flash_q <= ~flash_q;
  end

  assign bus.walk_flash = flash_q;
`else
  assign bus.walk_flash = 1'b0;
`endif

endmodule

// File: tb/tb_ped_crossing_scheduler.sv
// Bench for ped_crossing_scheduler: hand-derived vector table, a couple of
// explicit sequences, then random traffic against a timestamp-based model.
module tb_ped_crossing_scheduler;

  localparam int N  = 4;
  localparam int MG = 8;
  localparam int W  = 6;
  localparam int C  = 2;
  localparam int HT = 16;
`ifdef PED_FLASH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk_main = 1'b0;
  logic rst_main = 1'b1;
  always #5 clk_main = ~clk_main;

  ped_crossing_scheduler_if #(.N_XWALK(N)) bus ();

  ped_crossing_scheduler #(
    .N_XWALK(N), .MIN_GAP(MG), .WALK_CYCLES(W), .CLEAR_CYCLES(C), .HOLD_TIMEOUT(HT)
  ) dut (
    .clk_main (clk_main),
    .rst_main (rst_main),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: phases are derived from timestamps, not a state machine.
  // rel = first idle cycle after release, hs = first hold cycle,
  // gs = first walk cycle, cyc = index of the cycle now visible.
  int       cyc = 0;
  int       rel = 0, hs = -1, gs = -1, win = 0, ptr = 0;
  bit       m_fault = 0;
  bit [3:0] mp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input logic [3:0] rq, input logic [1:0] lt);
    int c;
    bit [3:0] drop;
    bit found;
    c = cyc;
    drop = '0;
    if (r) begin
      mp = '0; rel = c + 1; hs = -1; gs = -1; ptr = 0; m_fault = 0; win = 0;
    end else begin
      if (gs >= 0 && c < gs + W) drop[win] = 1'b1;
      if (hs < 0) begin
        if (mp != 0 && c - rel >= MG) hs = c + 1;
      end else if (gs < 0) begin
        if (lt == 2'b10) begin
          found = 0;
          for (int k = 0; k < N; k++)
            if (!found && mp[(ptr + k) % N]) begin
              found = 1;
              win   = (ptr + k) % N;
            end
          gs = c + 1;
          ptr = (win + 1) % N;
          drop[win] = 1'b1;
        end else if (c - hs + 1 >= HT) begin
          m_fault = 1;
        end
      end else if (c == gs + W + C - 1) begin
        rel = c + 1; hs = -1; gs = -1;
      end
      mp = (mp | rq) & ~drop;
    end
    cyc++;
  endtask

  function automatic bit m_hold();
    return hs >= 0 && cyc >= hs;
  endfunction

  function automatic bit m_walk();
    return gs >= 0 && cyc >= gs && cyc < gs + W;
  endfunction

  task automatic check_model();
    logic [3:0] eg;
    bit ef;
    eg = m_walk() ? 4'(1 << win) : 4'b0;
    ef = FL && m_walk() && (cyc - gs) >= W / 2 && ((cyc - gs - W / 2) % 2 == 0);
    chk("m_hold_red", bus.hold_red, m_hold());
    chk("m_walk_grant", bus.walk_grant, eg);
    chk("m_pending", bus.pending, mp);
    chk("m_hold_fault", bus.hold_fault, m_fault);
    chk("m_walk_flash", bus.walk_flash, ef);
  endtask

  task automatic step(input bit r, input logic [3:0] rq, input logic [1:0] lt);
    rst_main = r;
    bus.ped_req = rq;
    bus.traffic_light = lt;
    @(posedge clk_main);
    model_edge(r, rq, lt);
    #1;
    check_model();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [1:0] lt;
    int         n;
    bit         hold;
    logic [3:0] grant;
    logic [3:0] pend;
    bit         fault;
    bit         flash;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r, logic [3:0] rq, logic [1:0] lt, int n,
                             bit h, logic [3:0] g, logic [3:0] p, bit f, bit fl);
    vec_t x;
    x.rst = r; x.req = rq; x.lt = lt; x.n = n;
    x.hold = h; x.grant = g; x.pend = p; x.fault = f; x.flash = fl;
    return x;
  endfunction

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;

  initial begin
    bus.ped_req = '0;
    bus.traffic_light = G;

    // reset, idle, single request
    tbl.push_back(v(1, 4'b0000, G, 3,  0, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 20, 0, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0001, G, 1,  0, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 1,  1, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 1,  1, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0001, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 5,  1, 4'b0001, 4'b0000, 0, FL));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 1,  1, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 1,  0, 4'b0000, 4'b0000, 0, 0));
    // request right after release: gap enforced
    tbl.push_back(v(0, 4'b0100, G, 1,  0, 4'b0000, 4'b0100, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 7,  0, 4'b0000, 4'b0100, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 1,  1, 4'b0000, 4'b0100, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0100, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 6,  1, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 2,  0, 4'b0000, 4'b0000, 0, 0));
    // light stuck at yellow: timeout, then late red still walks
    tbl.push_back(v(0, 4'b0001, Y, 1,  0, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, Y, 8,  1, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, Y, 15, 1, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, Y, 1,  1, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0001, 4'b0000, 1, 0));
    tbl.push_back(v(0, 4'b0000, R, 8,  0, 4'b0000, 4'b0000, 1, 0));
    // reset clears fault; round robin 0001, 0010, 1000
    tbl.push_back(v(1, 4'b0000, G, 2,  0, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b1011, G, 1,  0, 4'b0000, 4'b1011, 0, 0));
    tbl.push_back(v(0, 4'b0000, G, 8,  1, 4'b0000, 4'b1011, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0001, 4'b1010, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 8,  0, 4'b0000, 4'b1010, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 9,  1, 4'b0000, 4'b1010, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0010, 4'b1000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 8,  0, 4'b0000, 4'b1000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 9,  1, 4'b0000, 4'b1000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b1000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 8,  0, 4'b0000, 4'b0000, 0, 0));
    // pointer back at 0; press on walking crosswalk dropped; mid-WALK reset
    tbl.push_back(v(0, 4'b1111, R, 1,  0, 4'b0000, 4'b1111, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 8,  1, 4'b0000, 4'b1111, 0, 0));
    tbl.push_back(v(0, 4'b0000, R, 1,  1, 4'b0001, 4'b1110, 0, 0));
    tbl.push_back(v(0, 4'b0001, R, 3,  1, 4'b0001, 4'b1110, 0, FL));
    tbl.push_back(v(1, 4'b0000, R, 1,  0, 4'b0000, 4'b0000, 0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].req, tbl[i].lt);
      chk($sformatf("vec%0d_hold_red", i), bus.hold_red, tbl[i].hold);
      chk($sformatf("vec%0d_walk_grant", i), bus.walk_grant, tbl[i].grant);
      chk($sformatf("vec%0d_pending", i), bus.pending, tbl[i].pend);
      chk($sformatf("vec%0d_hold_fault", i), bus.hold_fault, tbl[i].fault);
      chk($sformatf("vec%0d_walk_flash", i), bus.walk_flash, tbl[i].flash);
    end

    // Invalid light encoding must not count as red.
    begin
      int k;
      step(1, 4'b0000, G);
      step(0, 4'b0010, X);
      k = 0;
      while (bus.hold_red !== 1'b1 && k < 40) begin
        step(0, 4'b0000, X);
        k++;
      end
      chk("hold_wait_in_budget", k < 40, 1);
      for (int i = 0; i < 3; i++) begin
        step(0, 4'b0000, X);
        chk("invalid_light_no_grant", bus.walk_grant, 4'b0000);
      end
      step(0, 4'b0000, R);
      chk("red_after_invalid_grant", bus.walk_grant, 4'b0010);
    end

    // Random traffic checked every cycle by the model.
    step(1, 4'b0000, G);
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] rq;
      logic [1:0] lt;
      bit r;
      r  = ($urandom_range(0, 599) == 0);
      rq = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      if (m_hold()) lt = ($urandom_range(0, 3) == 0) ? R : 2'($urandom_range(0, 3));
      else lt = 2'($urandom);
      step(r, rq, lt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
